// File: rtl/mf8_regfile_w.sv
// mf8 register file: two registered read ports, delayed-address byte/pair write with
// forwarding, X/Y/Z pointer shadows and a post-reset clear sweep.
module mf8_regfile_w #(
  parameter int unsigned DW             = 8,
  parameter int unsigned NREG           = 32,
  parameter int unsigned AW             = 5,
  parameter int unsigned PTR_BASE       = NREG - 6,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_wr,
  input  logic            i_wr_word,
  input  logic [AW-1:0]   i_rd_addr,
  input  logic [AW-1:0]   i_rr_addr,
  input  logic [2*DW-1:0] i_data_in,
  output logic [DW-1:0]   o_rd_data,
  output logic [DW-1:0]   o_rr_data,
  output logic [2*DW-1:0] o_x,
  output logic [2*DW-1:0] o_y,
  output logic [2*DW-1:0] o_z,
  output logic            o_busy
);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e              r_state, w_state_d;
  logic [AW-1:0]       r_cnt, w_cnt_d;
  logic [AW-1:0]       r_rd_addr;
  logic                r_busy, w_busy_d;
  logic [DW-1:0]       r_rd_data, w_rd_data_d;
  logic [DW-1:0]       r_rr_data, w_rr_data_d;
  logic [5:0][DW-1:0]  r_ptr, w_ptr_d;

  // Two copies so each read port has its own array read.
  logic [DW-1:0]       r_mem_a [NREG];
  logic [DW-1:0]       r_mem_b [NREG];

  logic                w_clr, w_wr_run;
  logic                w_we0, w_we1;
  logic [AW-1:0]       w_wa0, w_wa1;
  logic [DW-1:0]       w_wd0, w_wd1;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_busy_d  = 1'b0;
    unique case (r_state)
      StClear: begin
        w_busy_d = 1'b1;
        w_cnt_d  = r_cnt + 1'b1;
        if (r_cnt == AW'(NREG - 1)) begin
          w_state_d = StRun;
          w_busy_d  = 1'b0;
        end
      end
      StRun: begin
        w_state_d = StRun;
      end
      default: w_state_d = StRun;
    endcase
  end

  // Port 0 carries the clear sweep, byte writes and the even half of pair writes.
  always_comb begin
    w_clr    = (r_state == StClear);
    w_wr_run = i_wr & ~r_busy;
    w_we0    = w_clr | w_wr_run;
    w_wa0    = w_clr ? r_cnt : (i_wr_word ? {r_rd_addr[AW-1:1], 1'b0} : r_rd_addr);
    w_wd0    = w_clr ? '0 : i_data_in[DW-1:0];
    w_we1    = ~w_clr & w_wr_run & i_wr_word;
    w_wa1    = {r_rd_addr[AW-1:1], 1'b1};
    w_wd1    = i_data_in[2*DW-1:DW];
  end

  always_comb begin
    w_rd_data_d = '0;
    w_rr_data_d = '0;
    if (!r_busy) begin
      w_rd_data_d = r_mem_a[i_rd_addr];
      w_rr_data_d = r_mem_b[i_rr_addr];
      if (w_we0 && w_wa0 == i_rd_addr) w_rd_data_d = w_wd0;
      if (w_we1 && w_wa1 == i_rd_addr) w_rd_data_d = w_wd1;
      if (w_we0 && w_wa0 == i_rr_addr) w_rr_data_d = w_wd0;
      if (w_we1 && w_wa1 == i_rr_addr) w_rr_data_d = w_wd1;
    end
  end

  always_comb begin
    w_ptr_d = r_ptr;
    for (int k = 0; k < 6; k++) begin
      if (w_we0 && w_wa0 == AW'(PTR_BASE + k)) w_ptr_d[k] = w_wd0;
      if (w_we1 && w_wa1 == AW'(PTR_BASE + k)) w_ptr_d[k] = w_wd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      if (CLEAR_ON_RESET) r_state <= StClear;
      else                r_state <= StRun;
      r_cnt     <= '0;
      r_rd_addr <= '0;
      r_busy    <= 1'b1;
      r_rd_data <= '0;
      r_rr_data <= '0;
      r_ptr     <= '0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_rd_addr <= i_rd_addr;
      r_busy    <= w_busy_d;
      r_rd_data <= w_rd_data_d;
      r_rr_data <= w_rr_data_d;
      r_ptr     <= w_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_we0) begin
      r_mem_a[w_wa0] <= w_wd0;
      r_mem_b[w_wa0] <= w_wd0;
    end
    if (w_we1) begin
      r_mem_a[w_wa1] <= w_wd1;
      r_mem_b[w_wa1] <= w_wd1;
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_rr_data = r_rr_data;
  assign o_x       = {r_ptr[1], r_ptr[0]};
  assign o_y       = {r_ptr[3], r_ptr[2]};
  assign o_z       = {r_ptr[5], r_ptr[4]};
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_mf8_regfile_w.sv
// Directed bench for mf8_regfile_w: default 8x32 instance plus a 16x16 no-clear instance.
module tb_mf8_regfile_w;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, wr, wr_word, busy;
  logic [4:0]  rd_addr, rr_addr;
  logic [15:0] data_in, x, y, z;
  logic [7:0]  rd_data, rr_data;

  logic        rst_b_n, wr_b, wr_word_b, busy_b;
  logic [3:0]  rd_addr_b, rr_addr_b;
  logic [31:0] data_in_b, x_b, y_b, z_b;
  logic [15:0] rd_data_b, rr_data_b;

  mf8_regfile_w u_dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_wr      (wr),
    .i_wr_word (wr_word),
    .i_rd_addr (rd_addr),
    .i_rr_addr (rr_addr),
    .i_data_in (data_in),
    .o_rd_data (rd_data),
    .o_rr_data (rr_data),
    .o_x       (x),
    .o_y       (y),
    .o_z       (z),
    .o_busy    (busy)
  );

  mf8_regfile_w #(
    .DW             (16),
    .NREG           (16),
    .AW             (4),
    .CLEAR_ON_RESET (1'b0)
  ) u_dut_b (
    .i_clk     (clk),
    .i_rst_n   (rst_b_n),
    .i_wr      (wr_b),
    .i_wr_word (wr_word_b),
    .i_rd_addr (rd_addr_b),
    .i_rr_addr (rr_addr_b),
    .i_data_in (data_in_b),
    .o_rd_data (rd_data_b),
    .o_rr_data (rr_data_b),
    .o_x       (x_b),
    .o_y       (y_b),
    .o_z       (z_b),
    .o_busy    (busy_b)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until busy drops, bounded so a stuck DUT still reaches the summary.
  task automatic wait_busy(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (busy && n < 100);
  endtask

  int n;

  initial begin
    rst_n = 1'b0; wr = 1'b0; wr_word = 1'b0; rd_addr = '0; rr_addr = '0; data_in = '0;
    rst_b_n = 1'b0; wr_b = 1'b0; wr_word_b = 1'b0; rd_addr_b = '0; rr_addr_b = '0;
    data_in_b = '0;
    step();
    step();
    push("rst_busy", 1);     check(32'(busy));
    push("rst_rd", 0);       check(32'(rd_data));
    push("rst_x", 0);        check(32'(x));
    push("rst_busy_b", 1);   check(32'(busy_b));

    // Release with writes requested throughout the sweep; all must be ignored.
    rst_n = 1'b1; wr = 1'b1; data_in = 16'h00FF; rd_addr = 5'd7;
    wait_busy(n);
    wr = 1'b0;
    push("busy_edges", 32);  check(32'(n));
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      rr_addr = 5'(31 - i);
      push("clr_rd", 0);
      push("clr_rr", 0);
      step();
      check(32'(rd_data));
      check(32'(rr_data));
    end
    push("clr_x", 0); check(32'(x));
    push("clr_y", 0); check(32'(y));
    push("clr_z", 0); check(32'(z));

    // Byte write with forwarding to both ports.
    rd_addr = 5'd5; rr_addr = 5'd0;
    step();
    wr = 1'b1; data_in = 16'h00A5; rd_addr = 5'd5; rr_addr = 5'd5;
    push("fwd_rd", 8'hA5); push("fwd_rr", 8'hA5);
    step();
    check(32'(rd_data)); check(32'(rr_data));
    wr = 1'b0;
    push("r5_read", 8'hA5);
    step();
    check(32'(rd_data));

    // Pair write into Y with per-byte forwarding.
    rd_addr = 5'd29;
    step();
    wr = 1'b1; wr_word = 1'b1; data_in = 16'h1234; rd_addr = 5'd28; rr_addr = 5'd29;
    push("pair_fwd_rd", 8'h34); push("pair_fwd_rr", 8'h12);
    step();
    check(32'(rd_data)); check(32'(rr_data));
    wr = 1'b0; wr_word = 1'b0;
    push("pair_y", 16'h1234); check(32'(y));
    push("pair_r28", 8'h34); push("pair_r29", 8'h12);
    step();
    check(32'(rd_data)); check(32'(rr_data));

    // Consecutive byte writes build Z.
    rd_addr = 5'd30;
    step();
    wr = 1'b1; data_in = 16'h00EF; rd_addr = 5'd31;
    step();
    push("z_low", 16'h00EF); check(32'(z));
    data_in = 16'h00BE; rd_addr = 5'd0;
    step();
    wr = 1'b0;
    push("z_full", 16'hBEEF); check(32'(z));
    push("z_x", 0);           check(32'(x));
    push("z_y", 16'h1234);    check(32'(y));

    // Write r3, then reset, abort the sweep at cnt=10 and let it restart.
    rd_addr = 5'd3;
    step();
    wr = 1'b1; data_in = 16'h0055; rr_addr = 5'd3;
    push("r3_fwd", 8'h55);
    step();
    check(32'(rd_data));
    wr = 1'b0;
    rst_n = 1'b0;
    #1;
    push("rst2_busy", 1); check(32'(busy));
    push("rst2_rd", 0);   check(32'(rd_data));
    push("rst2_y", 0);    check(32'(y));
    push("rst2_z", 0);    check(32'(z));
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    push("mid_busy", 1); check(32'(busy));
    rst_n = 1'b0;
    #1;
    push("abort_busy", 1); check(32'(busy));
    push("abort_rr", 0);   check(32'(rr_data));
    step();
    rst_n = 1'b1;
    wait_busy(n);
    push("restart_edges", 32); check(32'(n));
    rd_addr = 5'd3; rr_addr = 5'd30;
    push("r3_cleared", 0); push("r30_cleared", 0);
    step();
    check(32'(rd_data)); check(32'(rr_data));

    // Wide instance without clear sweep: pair write into Z.
    rd_addr_b = 4'd14;
    rst_b_n = 1'b1;
    step();
    push("b_busy_fall", 0); check(32'(busy_b));
    wr_b = 1'b1; wr_word_b = 1'b1; data_in_b = 32'hCAFEF00D; rd_addr_b = 4'd14;
    rr_addr_b = 4'd15;
    push("b_fwd_rd", 16'hF00D); push("b_fwd_rr", 16'hCAFE);
    step();
    check(32'(rd_data_b)); check(32'(rr_data_b));
    wr_b = 1'b0; wr_word_b = 1'b0;
    push("b_z", 32'hCAFEF00D); check(z_b);
    push("b_x", 0);            check(x_b);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
